inv_sub_bytes_iter: RTL and testbench
=====================================

Name: inv_sub_bytes_iter

Overview:
- Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse counterpart of the forward byte-substitution step.
- Accepts a 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through shared inverse S-box instances.
- Returns the result over a second valid/ready handshake, so the AES inverse-round controller can trade area against latency.

Parameters:
- BYTES_PER_CYCLE, 4, number of inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise).
- TAG_W, 4, width of the sideband tag (e.g. round index) carried with the state.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input state available
- in_ready  output  1  engine can accept a state
- in_state  input  128  ciphertext-side state; byte i = in_state[127-8i -: 8], byte 0 is the MSB
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_state  output  128  substituted state, same byte order as in_state
- out_tag  output  TAG_W  tag captured with the state
- abort  input  1  synchronous flush to IDLE
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: FSM=IDLE, group counter=0, working register=0, tag=0. Outputs: in_ready=1, out_valid=0, busy=0, out_state=0, out_tag=0.
- Derived constant: K = 16/BYTES_PER_CYCLE. The counter is clog2(K) bits wide, with a minimum of 1 bit.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = ~abort.
  - On in_valid & in_ready: load the working register from in_state and the tag register from in_tag; set cnt=0; go to RUN.
- RUN:
  - Each cycle, bytes cnt*BYTES_PER_CYCLE .. cnt*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 are replaced in place by InvSbox(byte). All other bytes are held.
  - cnt increments. When cnt==K-1, cnt wraps to 0 and the FSM goes to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1.
  - out_state and out_tag are stable until out_ready=1. On out_ready, go to IDLE.
  - in_ready=0 in DONE, including the handshake cycle. There is no same-cycle turnaround.
- Latency: out_valid rises exactly K clock edges after the accepting edge. Throughput is one state per K+2 cycles when out_ready is held high.
  - Example: BYTES_PER_CYCLE=4 gives K=4.
- out_state and out_tag are driven directly from the working and tag registers at all times. They are meaningful only when out_valid=1.
- abort:
  - In any state, abort=1 at an edge forces IDLE with cnt=0.
  - The working and tag registers are left unchanged; no partial result is flushed out.
  - Priority: reset > abort > handshake.
  - abort in DONE together with out_ready still counts as a drop: the consumer sees out_valid fall. The consumer must not sample on abort.
- Reset asserted mid-RUN or mid-DONE returns everything to reset values immediately. The next transaction is unaffected.
- Holding in_valid high in RUN or DONE has no effect. in_state changes during RUN are ignored.
- InvSbox is the FIPS-197 inverse table, exactly the inverse of the forward S-box: InvSbox(Sbox(x)) = x for all 256 values.

Decomposition:
- Shared package aes_pkg holds:
  - AES_STATE_W=128, AES_BYTE_W=8, AES_NBYTES=16.
  - The FSM state enum (IDLE/RUN/DONE).
  - A byte-index helper function giving the bit offset 127-8i.
- Sub-module inv_s_box (in_byte[7:0] -> c[7:0]):
  - Combinational 256-entry inverse lookup.
  - Instantiated BYTES_PER_CYCLE times, fed by a byte mux selected by cnt.

Test Plan:
- Reset, then in_state=0x637c777bf26b6fc53001672bfed7ab76, tag=0x3, BYTES_PER_CYCLE=4, out_ready=1 -> out_valid exactly 4 cycles after accept; out_state=0x000102030405060708090a0b0c0d0e0f; out_tag=0x3.
- All-0x63 state -> all-0x00. All-0x16 state -> all-0xff. State of all 0x52 bytes -> all 0x48. Repeat for BYTES_PER_CYCLE=1 (latency 16) and 16 (latency 1).
- out_ready held low 10 cycles in DONE -> out_valid and out_state stable, in_ready=0 throughout; then out_ready=1 -> next cycle in_ready=1, out_valid=0.
- abort asserted in the 2nd RUN cycle -> next cycle IDLE, in_ready=1, busy=0. A new state 0xed repeated 16 times -> 0x53 repeated 16 times with full latency.
- rst_n pulsed low mid-RUN (asynchronous, between edges) -> out_valid=0, in_ready=1, out_state=0 immediately; subsequent transaction correct.
- Exhaustive: 16 transactions covering all 256 byte values (bytes 16j..16j+15) -> each output byte equals its FIPS-197 inverse; random back-to-back traffic with random out_ready stalls checked against a reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte-position helper for the cipher datapath.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_iter_state_e;

    // Byte 0 is the most significant byte, so byte i starts at bit 127-8i.
    function automatic logic [6:0] byteMsb(input logic [3:0] idx);
        return 7'd127 - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// Combinational FIPS-197 inverse S-box lookup, one byte in, one byte out.
module inv_s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] c
);

    // Entry 0 sits in the top byte, so entry x starts at bit 2047-8x = {~x, 3'b111}.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Pure table read; no state.
    always_comb begin
        c = INV_SBOX[{~in_byte, 3'b111} -: 8];
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock through shared inverse S-boxes.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4,
    parameter int TAG_W           = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   abort,
    output logic                   busy
);

    localparam int K     = AES_NBYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : gBadBytesPerCycle
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    aes_iter_state_e        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [TAG_W-1:0]       tag_q, tag_d;

    logic [3:0]            selIdx  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0] sboxIn  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0] sboxOut [BYTES_PER_CYCLE];

    // The counter picks which group of bytes the shared S-boxes see this cycle.
    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : gSbox
        assign selIdx[j] = 4'(int'(cnt_q) * BYTES_PER_CYCLE + j);
        assign sboxIn[j] = work_q[byteMsb(selIdx[j]) -: AES_BYTE_W];

        inv_s_box uInvSbox (
            .in_byte (sboxIn[j]),
            .c       (sboxOut[j])
        );
    end

    // State, counter, working and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            tag_q   <= tag_d;
        end
    end

    // Next-state and handshake outputs; abort overrides everything but leaves data untouched.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        tag_d     = tag_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = ~abort;
                if (in_valid && !abort) begin
                    work_d  = in_state;
                    tag_d   = in_tag;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    work_d[byteMsb(selIdx[j]) -: AES_BYTE_W] = sboxOut[j];
                end
                if (cnt_q == CNT_W'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            work_d  = work_q;
            tag_d   = tag_q;
        end
    end

    assign out_state = work_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter at 1, 4 and 16 bytes per cycle.
module tb_inv_sub_bytes_iter;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic [127:0] inState;
    logic [3:0]   inTag;
    logic         outReady;
    logic         abort;

    logic         inReady1, inReady4, inReady16;
    logic         outValid1, outValid4, outValid16;
    logic [127:0] outState1, outState4, outState16;
    logic [3:0]   outTag1, outTag4, outTag16;
    logic         busy1, busy4, busy16;

    int nVec;
    int nMis;

    logic [2047:0] fwdTable;
    logic [7:0]    fwd [256];
    logic [7:0]    inv [256];

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady4),
        .in_state(inState), .in_tag(inTag), .out_valid(outValid4), .out_ready(outReady),
        .out_state(outState4), .out_tag(outTag4), .abort(abort), .busy(busy4)
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady1),
        .in_state(inState), .in_tag(inTag), .out_valid(outValid1), .out_ready(outReady),
        .out_state(outState1), .out_tag(outTag1), .abort(abort), .busy(busy1)
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady16),
        .in_state(inState), .in_tag(inTag), .out_valid(outValid16), .out_ready(outReady),
        .out_state(outState16), .out_tag(outTag16), .abort(abort), .busy(busy16)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] invModel(input logic [127:0] st);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = inv[st[127 - 8*k -: 8]];
        return r;
    endfunction

    // Offer one state to the 4-byte engine; returns just after the accepting edge.
    task automatic applyStimulus(input logic [127:0] st, input logic [3:0] tg);
        int n = 0;
        while (!inReady4 && n < 50) begin
            tick;
            n++;
        end
        checkOutput("acceptReady", 128'(inReady4), 128'(1));
        inValid = 1'b1;
        inState = st;
        inTag   = tg;
        tick;
        inValid = 1'b0;
        inState = {4{32'hdeadbeef}};
    endtask

    // Wait (bounded) for the 4-byte engine's result, check it and complete the handshake.
    task automatic waitResult(input string name, input int expLat, input logic [127:0] expSt,
                              input logic [3:0] expTag);
        int n = 0;
        do begin
            tick;
            n++;
        end while (!outValid4 && n < 40);
        checkOutput({name, "Lat"}, 128'(n), 128'(expLat));
        checkOutput({name, "State"}, outState4, expSt);
        checkOutput({name, "Tag"}, 128'(outTag4), 128'(expTag));
        tick;
    endtask

    // Push one state into all three engines at once and compare latency and result of each.
    task automatic runAll(input string name, input logic [127:0] st, input logic [127:0] expSt,
                          input logic [3:0] tg);
        int n = 0;
        int lat1 = -1, lat4 = -1, lat16 = -1;
        logic [127:0] s1 = '0, s4 = '0, s16 = '0;
        logic [3:0] t4 = '0;
        while (!(inReady1 && inReady4 && inReady16) && n < 40) begin
            tick;
            n++;
        end
        outReady = 1'b1;
        inValid  = 1'b1;
        inState  = st;
        inTag    = tg;
        tick;
        inValid = 1'b0;
        inState = '1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (outValid1 && lat1 < 0) begin lat1 = i; s1 = outState1; end
            if (outValid4 && lat4 < 0) begin lat4 = i; s4 = outState4; t4 = outTag4; end
            if (outValid16 && lat16 < 0) begin lat16 = i; s16 = outState16; end
        end
        checkOutput({name, "Lat1"}, 128'(lat1), 128'(16));
        checkOutput({name, "Lat4"}, 128'(lat4), 128'(4));
        checkOutput({name, "Lat16"}, 128'(lat16), 128'(1));
        checkOutput({name, "State1"}, s1, expSt);
        checkOutput({name, "State4"}, s4, expSt);
        checkOutput({name, "State16"}, s16, expSt);
        checkOutput({name, "Tag4"}, 128'(t4), 128'(tg));
    endtask

    initial begin
        logic [127:0] st, ex, held;
        logic [127:0] rs;
        logic [3:0]   rt;
        logic [131:0] q[$];
        logic [131:0] front;
        logic         accepted;
        int           nOut;

        nVec = 0;
        nMis = 0;
        fwdTable = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        for (int i = 0; i < 256; i++) begin
            fwd[i] = fwdTable[2047 - 8*i -: 8];
            inv[fwd[i]] = 8'(i);
        end

        rst_n    = 1'b0;
        inValid  = 1'b0;
        inState  = '0;
        inTag    = '0;
        outReady = 1'b1;
        abort    = 1'b0;

        // Reset values.
        tick;
        tick;
        checkOutput("rstInReady", 128'(inReady4), 128'(1));
        checkOutput("rstOutValid", 128'(outValid4), 128'(0));
        checkOutput("rstBusy", 128'(busy4), 128'(0));
        checkOutput("rstOutState", outState4, 128'(0));
        checkOutput("rstOutTag", 128'(outTag4), 128'(0));
        #3 rst_n = 1'b1;
        tick;

        // Directed vectors at all three widths.
        $display("[TB] directed vectors");
        runAll("fips", 128'h637c777bf26b6fc53001672bfed7ab76,
               128'h000102030405060708090a0b0c0d0e0f, 4'h3);
        runAll("all63", {16{8'h63}}, {16{8'h00}}, 4'h1);
        runAll("all16", {16{8'h16}}, {16{8'hff}}, 4'h2);
        runAll("all52", {16{8'h52}}, {16{8'h48}}, 4'h4);

        // Consumer stalls for 10 cycles in DONE.
        $display("[TB] output stall");
        outReady = 1'b0;
        applyStimulus({16{8'h52}}, 4'h5);
        begin
            int n = 0;
            while (!outValid4 && n < 40) begin
                tick;
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            checkOutput("stallValid", 128'(outValid4), 128'(1));
            checkOutput("stallState", outState4, {16{8'h48}});
            checkOutput("stallInReady", 128'(inReady4), 128'(0));
        end
        outReady = 1'b1;
        tick;
        checkOutput("releaseInReady", 128'(inReady4), 128'(1));
        checkOutput("releaseValid", 128'(outValid4), 128'(0));

        // Abort during the second RUN cycle.
        $display("[TB] abort");
        applyStimulus(128'h637c777bf26b6fc53001672bfed7ab76, 4'h7);
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        #1;
        checkOutput("abortInReady", 128'(inReady4), 128'(1));
        checkOutput("abortBusy", 128'(busy4), 128'(0));
        checkOutput("abortValid", 128'(outValid4), 128'(0));
        checkOutput("abortHeld", outState4, 128'h00010203f26b6fc53001672bfed7ab76);
        applyStimulus({16{8'hed}}, 4'h9);
        waitResult("afterAbort", 4, {16{8'h53}}, 4'h9);

        // Asynchronous reset in the middle of RUN.
        $display("[TB] reset mid-run");
        applyStimulus({16{8'h16}}, 4'ha);
        tick;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 128'(outValid4), 128'(0));
        checkOutput("midRstInReady", 128'(inReady4), 128'(1));
        checkOutput("midRstState", outState4, 128'(0));
        checkOutput("midRstBusy", 128'(busy4), 128'(0));
        #2 rst_n = 1'b1;
        tick;
        applyStimulus(128'h637c777bf26b6fc53001672bfed7ab76, 4'hb);
        waitResult("afterRst", 4, 128'h000102030405060708090a0b0c0d0e0f, 4'hb);

        // Every byte value: feed S-box images so each output byte must equal its index.
        $display("[TB] exhaustive bytes");
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) begin
                st[127 - 8*k -: 8] = fwd[16*j + k];
                ex[127 - 8*k -: 8] = 8'(16*j + k);
            end
            applyStimulus(st, 4'(j));
            waitResult("exh", 4, ex, 4'(j));
        end

        // Back-to-back random traffic with random consumer stalls.
        $display("[TB] random traffic");
        nOut     = 0;
        held     = '0;
        rs       = {$urandom, $urandom, $urandom, $urandom};
        rt       = 4'($urandom);
        inValid  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            outReady = ($urandom_range(0, 3) != 0);
            inState  = rs;
            inTag    = rt;
            #1;
            accepted = inValid && inReady4;
            if (accepted) q.push_back({rt, invModel(rs)});
            if (outValid4 && outReady) begin
                nOut++;
                if (q.size() == 0) begin
                    checkOutput("rndUnexpected", 128'(1), 128'(0));
                end else begin
                    front = q.pop_front();
                    checkOutput("rndState", outState4, front[127:0]);
                    checkOutput("rndTag", 128'(outTag4), 128'(front[131:128]));
                end
            end
            tick;
            if (accepted) begin
                rs = {$urandom, $urandom, $urandom, $urandom};
                rt = 4'($urandom);
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("rndProgress", 128'(nOut > 50), 128'(1));
        tick;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
